// File: rtl/add_num_rd_engine.sv
// Operand-fetch stage of the add-two-numbers AFU: one c0 read, extract two operands, hand the sum downstream.
// Optional response timeout is compiled in with `define ADD_NUM_RD_TIMEOUT_EN.
module add_num_rd_engine #(
  parameter int          OP_W     = 8,
  parameter int          OP_A_LSB = 8,
  parameter int          OP_B_LSB = 16,
  parameter logic [15:0] MDATA_ID = 16'hA5D0,
  parameter int          TMO_CYC  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [41:0]   start_addr,
  output logic          busy,
  input  logic          c0_almfull,
  output logic          rd_valid,
  output logic [41:0]   rd_addr,
  output logic [15:0]   rd_mdata,
  input  logic          rsp_valid,
  input  logic [15:0]   rsp_mdata,
  input  logic [511:0]  rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OP_W:0] out_sum,
  output logic          out_err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] REQ      = 3'd1;
  localparam logic [2:0] WAIT_RSP = 3'd2;
  localparam logic [2:0] SUM      = 3'd3;
  localparam logic [2:0] OUT      = 3'd4;

  if (OP_W < 1 || OP_A_LSB < 0 || OP_B_LSB < 0 ||
      OP_A_LSB + OP_W > 512 || OP_B_LSB + OP_W > 512) begin : g_bad_field
    $error("add_num_rd_engine: operand field outside the 512-bit line");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("add_num_rd_engine: TMO_CYC must be at least 1");
  end

  // Zero-extend both operands so the carry lands in the extra sum bit.
  function automatic logic [OP_W:0] add_ops(input logic [OP_W-1:0] a,
                                            input logic [OP_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [2:0]      state;
  logic [41:0]     addr_q;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            rsp_match;
  logic            unused_rsp;

  assign busy       = (state != IDLE);
  assign rsp_match  = rsp_valid && (rsp_mdata == MDATA_ID);
  assign unused_rsp = ^rsp_data;

`ifdef ADD_NUM_RD_TIMEOUT_EN
  localparam int               CNT_W    = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_valid  <= 1'b0;
      rd_addr   <= '0;
      rd_mdata  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
`ifdef ADD_NUM_RD_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q <= start_addr;
            state  <= REQ;
          end
        end
        REQ: begin
          // Request goes out only while the c0 channel has room.
          if (!c0_almfull) begin
            rd_valid <= 1'b1;
            rd_addr  <= addr_q;
            rd_mdata <= MDATA_ID;
            state    <= WAIT_RSP;
`ifdef ADD_NUM_RD_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
          end
        end
        WAIT_RSP: begin
          if (rsp_match) begin
            op_a  <= rsp_data[OP_A_LSB +: OP_W];
            op_b  <= rsp_data[OP_B_LSB +: OP_W];
            state <= SUM;
          end
`ifdef ADD_NUM_RD_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            out_sum   <= '0;
            err_q     <= 1'b1;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        SUM: begin
          out_sum   <= add_ops(op_a, op_b);
          out_valid <= 1'b1;
`ifdef ADD_NUM_RD_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
          state     <= OUT;
        end
        OUT: begin
          // Result held until the writer takes it; start is not sampled here.
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef ADD_NUM_RD_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_num_rd_engine.sv
// Randomized bench for add_num_rd_engine: transaction-level expectations (read count/latency, operand sum).
module tb_add_num_rd_engine;

  localparam logic [15:0] MID = 16'hA5D0;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [41:0]  start_addr;
  logic         busy;
  logic         c0_almfull;
  logic         rd_valid;
  logic [41:0]  rd_addr;
  logic [15:0]  rd_mdata;
  logic         rsp_valid;
  logic [15:0]  rsp_mdata;
  logic [511:0] rsp_data;
  logic         out_valid;
  logic         out_ready;
  logic [8:0]   out_sum;
  logic         out_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int rd_cyc  = 0;
  int almfull_viol = 0;
  logic [41:0] rd_addr_seen;
  logic [15:0] rd_mdata_seen;

  add_num_rd_engine #(.TMO_CYC(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .busy(busy),
    .c0_almfull(c0_almfull), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_mdata(rd_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && rd_valid) begin
      rd_cnt++;
      rd_cyc = cyc;
      rd_addr_seen  = rd_addr;
      rd_mdata_seen = rd_mdata;
      if (c0_almfull) almfull_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] make_line(input logic [7:0] a, input logic [7:0] b);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    l[15:8]  = a;
    l[23:16] = b;
    return l;
  endfunction

  function automatic logic [41:0] rand_addr();
    return {10'($urandom), 32'($urandom)};
  endfunction

  // Start one operation (plus a second start while busy), hold almfull for af cycles, expect one read.
  task automatic issue(input logic [41:0] addr, input int af);
    int t0;
    rd_cnt = 0;
    almfull_viol = 0;
    start = 1'b1;
    start_addr = addr;
    c0_almfull = (af > 0);
    t0 = cyc;
    tick;
    start_addr = ~addr;
    c0_almfull = (af > 1);
    check("busy_after_start", busy, 1);
    tick;
    start = 1'b0;
    start_addr = '0;
    for (int i = 0; i < 40 && rd_cnt == 0; i++) begin
      c0_almfull = ((cyc - t0) < af);
      tick;
    end
    c0_almfull = 1'b0;
    check("rd_issued", rd_cnt, 1);
    check("rd_latency", rd_cyc - t0, (af < 2) ? 2 : af + 1);
    check("rd_addr", rd_addr_seen, addr);
    check("rd_mdata", rd_mdata_seen, MID);
  endtask

  // Return the line (optionally after a foreign-tag response), then drain the sum with bp cycles of backpressure.
  task automatic respond(input logic [7:0] a, input logic [7:0] b, input bit bad,
                         input int gap, input int bp, input bit hs_start);
    int e;
    e = a + b;
    out_ready = (bp == 0);
    repeat (gap) tick;
    if (bad) begin
      rsp_valid = 1'b1;
      rsp_mdata = 16'h1234;
      rsp_data  = make_line(~a, a ^ 8'h5A);
      tick;
    end
    rsp_valid = 1'b1;
    rsp_mdata = MID;
    rsp_data  = make_line(a, b);
    tick;
    rsp_valid = 1'b0;
    rsp_data  = make_line(8'hFF, 8'hFF);
    check("ovalid_early", out_valid, 0);
    tick;
    check("ovalid", out_valid, 1);
    check("sum", out_sum, e);
    check("err", out_err, 0);
    for (int j = 0; j < bp; j++) begin
      tick;
      check("hold_valid", out_valid, 1);
      check("hold_sum", out_sum, e);
    end
    out_ready = 1'b1;
    start = hs_start;
    start_addr = 42'h3FF;
    tick;
    start = 1'b0;
    out_ready = 1'b0;
    check("ovalid_drop", out_valid, 0);
    check("idle_after", busy, 0);
    check("single_rd", rd_cnt, 1);
    check("almfull_viol", almfull_viol, 0);
  endtask

  initial begin
    int quiet;
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    c0_almfull = 1'b0;
    rsp_valid = 1'b0;
    rsp_mdata = '0;
    rsp_data = '0;
    out_ready = 1'b0;
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", out_err, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_mdata", rd_mdata, 0);
    check("rst_out_sum", out_sum, 0);
    reset = 1'b0;
    tick;

    issue(42'h100, 0);       respond(8'h05, 8'h2D, 0, 0, 0, 0);
    issue(rand_addr(), 0);   respond(8'hFF, 8'hFF, 0, 1, 0, 1);
    issue(rand_addr(), 0);   respond(8'h00, 8'h00, 0, 0, 0, 0);
    issue(42'h2A5, 10);      respond(8'($urandom), 8'($urandom), 0, 2, 0, 0);
    issue(rand_addr(), 0);   respond(8'($urandom), 8'($urandom), 1, 1, 5, 1);

    for (int k = 0; k < 20; k++) begin
      issue(rand_addr(), $urandom_range(0, 3));
      respond(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom));
    end

    // Abort in WAIT_RSP; the stale response must not surface.
    issue(42'h5A5, 0);
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_out_sum", out_sum, 0);
    rsp_valid = 1'b1;
    rsp_mdata = MID;
    rsp_data  = make_line(8'h11, 8'h22);
    tick;
    rsp_valid = 1'b0;
    quiet = 0;
    repeat (6) begin
      if (out_valid || busy) quiet++;
      tick;
    end
    check("post_reset_quiet", quiet, 0);
    issue(rand_addr(), 0);
    respond(8'h80, 8'h7F, 0, 0, 1, 0);

`ifdef ADD_NUM_RD_TIMEOUT_EN
    begin
      int ov;
      issue(rand_addr(), 0);
      ov = -1;
      for (int i = 0; i < 100; i++) begin
        if (out_valid) begin
          ov = cyc;
          break;
        end
        tick;
      end
      check("tmo_latency", ov - rd_cyc, 16);
      check("tmo_err", out_err, 1);
      check("tmo_sum", out_sum, 0);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check("tmo_drop", out_valid, 0);
      rsp_valid = 1'b1;
      rsp_mdata = MID;
      rsp_data  = make_line(8'h01, 8'h02);
      tick;
      rsp_valid = 1'b0;
      repeat (4) tick;
      check("late_rsp_valid", out_valid, 0);
      check("late_rsp_busy", busy, 0);
    end
`else
    issue(rand_addr(), 0);
    repeat (100) tick;
    check("no_tmo_busy", busy, 1);
    check("no_tmo_valid", out_valid, 0);
    respond(8'h33, 8'h44, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
